// File: rtl/multiplexer_6_1.sv
// Six-way next-PC source mux with interrupt-vector override and an
// exception PC register that captures the selected source on interrupt onset.
module multiplexer_6_1 #(
    parameter int unsigned         WIDTH      = 32,
    parameter logic [WIDTH-1:0]    INT_VECTOR = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Data_in_0,
    input  logic [WIDTH-1:0] Data_in_1,
    input  logic [WIDTH-1:0] Data_in_2,
    input  logic [WIDTH-1:0] Data_in_3,
    input  logic [WIDTH-1:0] Data_in_4,
    input  logic [WIDTH-1:0] Data_in_5,
    input  logic             INTT,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] Data_out,
    output logic [WIDTH-1:0] EPC
);

    logic [WIDTH-1:0] w_sel_value;
    logic             w_onset;
    logic [WIDTH-1:0] r_epc_d;
    logic [WIDTH-1:0] r_epc_q;
    logic             r_intt_q;

    // Source select; the two unused codes yield zero so Data_out never goes X.
    always_comb begin
        w_sel_value = '0;
        case (sel)
            3'd0:    w_sel_value = Data_in_0;
            3'd1:    w_sel_value = Data_in_1;
            3'd2:    w_sel_value = Data_in_2;
            3'd3:    w_sel_value = Data_in_3;
            3'd4:    w_sel_value = Data_in_4;
            3'd5:    w_sel_value = Data_in_5;
            default: w_sel_value = '0;
        endcase
    end

    // Output path is purely combinational and independent of reset and EPC.
    always_comb begin
        Data_out = INTT ? INT_VECTOR : w_sel_value;
    end

    // Capture the interrupted PC (not the vector) only on the rising edge of INTT.
    always_comb begin
        w_onset = INTT && !r_intt_q;
        r_epc_d = w_onset ? w_sel_value : r_epc_q;
    end

    // State registers: INTT history and the exception PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intt_q <= 1'b0;
            r_epc_q  <= '0;
        end else begin
            r_intt_q <= INTT;
            r_epc_q  <= r_epc_d;
        end
    end

    assign EPC = r_epc_q;

endmodule

// File: tb/tb_multiplexer_6_1.sv
module tb_multiplexer_6_1;

    localparam int W = 32;
    localparam logic [W-1:0] VEC = 32'h0000_0080;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] d [6];
    logic         INTT;
    logic [2:0]   sel;
    logic [W-1:0] Data_out;
    logic [W-1:0] EPC;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_out_q [$];
    logic [W-1:0] exp_epc_q [$];
    logic [W-1:0] exp_v;

    // Bench-side reference state for the random phase
    logic [W-1:0] m_epc;
    logic         m_intt;

    multiplexer_6_1 #(
        .WIDTH      (W),
        .INT_VECTOR (VEC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Data_in_0 (d[0]),
        .Data_in_1 (d[1]),
        .Data_in_2 (d[2]),
        .Data_in_3 (d[3]),
        .Data_in_4 (d[4]),
        .Data_in_5 (d[5]),
        .INTT      (INTT),
        .sel       (sel),
        .Data_out  (Data_out),
        .EPC       (EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pick(input logic [2:0] s);
        if (s > 3'd5) return '0;
        return d[s];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        INTT  = 1'b0;
        sel   = 3'd0;
        for (int i = 0; i < 6; i++) d[i] = '0;
        #1;
        exp_out_q.push_back('0);
        exp_epc_q.push_back('0);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL reset_out: got %h expected %h", Data_out, exp_v);
        else n_pass++;
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL reset_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
        // Mux keeps working in reset; an edge with INTT high must not load EPC
        d[2] = 32'd9;
        sel  = 3'd2;
        INTT = 1'b1;
        #1;
        exp_out_q.push_back(VEC);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL reset_vec: got %h expected %h", Data_out, exp_v);
        else n_pass++;
        INTT = 1'b0;
        #1;
        exp_out_q.push_back(32'd9);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL reset_sel: got %h expected %h", Data_out, exp_v);
        else n_pass++;
        INTT = 1'b1;
        @(posedge clk); #1;
        exp_epc_q.push_back('0);
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL reset_hold_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
        @(negedge clk);
        INTT = 1'b0;
        d[2] = '0;
        sel  = 3'd0;
        rst_n = 1'b1;
    endtask

    task automatic test_select();
        logic [2:0] sels [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        logic [W-1:0] exps [6] = '{32'd0, 32'd3, 32'd7, 32'd1, 32'd0, 32'd0};
        @(negedge clk);
        d[2] = 32'd3;
        d[3] = 32'd7;
        d[4] = 32'd1;
        for (int i = 0; i < 6; i++) begin
            sel = sels[i];
            exp_out_q.push_back(exps[i]);
            #1;
            exp_v = exp_out_q.pop_front();
            n_checks++;
            if (Data_out !== exp_v)
                $display("FAIL select_sel%0d: got %h expected %h", sels[i], Data_out, exp_v);
            else n_pass++;
        end
        @(posedge clk); #1;
        exp_epc_q.push_back('0);
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL select_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
    endtask

    task automatic test_onset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) d[i] = 32'(10 + i);
        sel  = 3'd5;
        INTT = 1'b1;
        #1;
        exp_out_q.push_back(VEC);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL onset_out: got %h expected %h", Data_out, exp_v);
        else n_pass++;
        exp_epc_q.push_back(32'd15);
        @(posedge clk); #1;
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL onset_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
    endtask

    task automatic test_hold();
        @(negedge clk);
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            exp_epc_q.push_back(32'd15);
            exp_out_q.push_back(VEC);
            @(posedge clk); #1;
            exp_v = exp_epc_q.pop_front();
            n_checks++;
            if (EPC !== exp_v) $display("FAIL hold_epc%0d: got %h expected %h", i, EPC, exp_v);
            else n_pass++;
            exp_v = exp_out_q.pop_front();
            n_checks++;
            if (Data_out !== exp_v) $display("FAIL hold_out%0d: got %h expected %h", i, Data_out, exp_v);
            else n_pass++;
        end
        @(negedge clk);
        INTT = 1'b0;
        exp_epc_q.push_back(32'd15);
        @(posedge clk); #1;
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL hold_low_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
        @(negedge clk);
        INTT = 1'b1;
        exp_epc_q.push_back(32'd11);
        @(posedge clk); #1;
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL hold_recapture: got %h expected %h", EPC, exp_v);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_epc_q.push_back('0);
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL async_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
        INTT = 1'b0;
        sel  = 3'd3;
        #1;
        exp_out_q.push_back(32'd13);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL async_out: got %h expected %h", Data_out, exp_v);
        else n_pass++;
        INTT = 1'b1;
        sel  = 3'd0;
        @(posedge clk); #1;
        exp_out_q.push_back(VEC);
        exp_v = exp_out_q.pop_front();
        n_checks++;
        if (Data_out !== exp_v) $display("FAIL async_vec: got %h expected %h", Data_out, exp_v);
        else n_pass++;
    endtask

    task automatic test_release_onset();
        @(negedge clk);
        rst_n = 1'b1;
        exp_epc_q.push_back(32'd10);
        @(posedge clk); #1;
        exp_v = exp_epc_q.pop_front();
        n_checks++;
        if (EPC !== exp_v) $display("FAIL release_epc: got %h expected %h", EPC, exp_v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        m_epc  = 32'd10;
        m_intt = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            for (int k = 0; k < 6; k++) d[k] = $urandom;
            sel  = 3'($urandom_range(0, 7));
            INTT = ($urandom_range(0, 2) == 0);
            exp_out_q.push_back(INTT ? VEC : pick(sel));
            #1;
            exp_v = exp_out_q.pop_front();
            n_checks++;
            if (Data_out !== exp_v) $display("FAIL rand_out%0d: got %h expected %h", i, Data_out, exp_v);
            else n_pass++;
            if (INTT && !m_intt) m_epc = pick(sel);
            m_intt = INTT;
            exp_epc_q.push_back(m_epc);
            @(posedge clk); #1;
            exp_v = exp_epc_q.pop_front();
            n_checks++;
            if (EPC !== exp_v) $display("FAIL rand_epc%0d: got %h expected %h", i, EPC, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_onset();
        test_hold();
        test_async_reset();
        test_release_onset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
